gpio_irq_ctrl: RTL and testbench
================================

Name: gpio_irq_ctrl

Overview:
- Interrupt aggregator directly downstream of the GPIO pin-mux stage.
- Consumes the per-pin INTR vector and records rising edges as pending bits, subject to a mask.
- Presents one prioritized request (lowest index wins) to the CPU over a req/ack handshake.
- On acknowledge, drives the per-pin IRQRES pulse back into the pin-mux to clear the GPIO interrupt latch.

Parameters:
- NUM_PINS, 24, number of GPIO interrupt sources; matches the `NUM_PINS define.
- ID_W, 5, width of IRQ_ID; must satisfy 2**ID_W >= NUM_PINS.
- RES_CYCLES, 2, length in cycles of the IRQRES pulse; legal range 1..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- INTR  in  NUM_PINS  per-pin interrupt levels from the pin-mux.
- IRQ_MASK  in  NUM_PINS  1 = pin eligible for request.
- CLR_WE  in  1  software clear strobe.
- CLR_DATA  in  NUM_PINS  write-1-to-clear pending bits; qualified by CLR_WE.
- PENDING  out  NUM_PINS  pending register, readable by software.
- IRQ_REQ  out  1  interrupt request to CPU.
- IRQ_ID  out  ID_W  index of the requested pin; valid while IRQ_REQ=1, otherwise 0.
- IRQ_ACK  in  1  CPU acknowledge, single cycle.
- IRQRES  out  NUM_PINS  per-pin reset pulse to the pin-mux (IRQRES inputs).

Behaviour:
- Reset (RST=1 at an edge):
  - PENDING=0, IRQ_REQ=0, IRQ_ID=0, IRQRES=0, state=IDLE, RES counter=0.
  - intr_prev register=0, so an INTR bit already high after reset registers as an edge on the first post-reset edge.
  - Reset mid-handshake or mid-pulse aborts immediately; no IRQRES is completed.
- Edge detect: rise[i] = INTR[i] & ~intr_prev[i]; intr_prev <= INTR every cycle. Masked pins still record pending.
- Pending update per bit: next = rise[i] | (PENDING[i] & ~(CLR_WE & CLR_DATA[i]) & ~ack_clr[i]).
  - Set wins over a software clear or ack clear in the same cycle.
- eligible = PENDING & IRQ_MASK; winner = lowest set index of eligible.
- IDLE:
  - If eligible != 0 at an edge: IRQ_ID <= winner, IRQ_REQ <= 1, go to REQ.
  - Latency: INTR high before edge E0 -> PENDING[i]=1 after E0 -> IRQ_REQ=1, IRQ_ID=i after E1.
- REQ:
  - IRQ_ID is frozen; a higher-priority arrival does not preempt it.
  - IRQ_ACK=1 at an edge: IRQ_REQ <= 0, IRQ_ID <= 0, clear PENDING[IRQ_ID] (ack_clr) unless it re-rises that cycle, IRQRES[IRQ_ID] <= 1, counter <= RES_CYCLES-1, go to RES.
  - Withdraw: if the frozen pin's eligible bit drops (software clear or mask off) without an ack, IRQ_REQ <= 0, IRQ_ID <= 0, go to IDLE, and no IRQRES is issued.
  - Ack takes precedence over withdraw in the same cycle.
- RES:
  - IRQRES one-hot on the acknowledged pin for exactly RES_CYCLES cycles; counter decrements each cycle.
  - At counter=0: IRQRES <= 0, go to IDLE.
  - IRQ_REQ stays 0 for at least RES_CYCLES+1 cycles after the ack.
  - New edges are still recorded, including on the same pin.
- IRQ_ACK in IDLE or RES is ignored.
- At most one IRQRES bit is high at any time.
- Width rules: IRQ_ID is zero-extended from the encoder. Bits at index NUM_PINS and above do not exist.

Test Plan:
- Single source: RST, mask=all 1s, INTR[5] 0->1 -> PENDING=0x000020 after 1 edge; IRQ_REQ=1, IRQ_ID=5 after 2 edges; ACK -> PENDING=0, IRQRES=0x000020 for exactly 2 cycles, then 0.
- Priority: INTR[3] and INTR[17] rise together -> IRQ_ID=3. After ack plus 2-cycle pulse, IRQ_ID=17 one cycle after RES exits. INTR[1] rising during REQ(17) does not change IRQ_ID; it is served next.
- Mask: IRQ_MASK[9]=0, INTR[9] rises -> PENDING[9]=1, IRQ_REQ stays 0. Set mask bit -> IRQ_REQ=1, IRQ_ID=9 next cycle.
- Withdraw/clear: in REQ(ID=4), CLR_WE=1, CLR_DATA=0x000010 -> IRQ_REQ=0 next cycle, no IRQRES. Simultaneous rise[4] with the clear -> PENDING[4] stays 1.
- Held level: INTR[0] held high with no new edge -> exactly one pending/request. After ack, PENDING[0]=0 and no re-request.
- Reset mid-op: RST during RES -> IRQRES=0, PENDING=0, IRQ_REQ=0 next cycle. INTR[2] high across reset -> PENDING[2]=1 one edge after RST deasserts.

Source files
------------

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt aggregator: records rising edges of the pin-mux INTR vector as pending bits,
// presents the lowest-index eligible pin to the CPU over req/ack, and pulses IRQRES on ack.
module gpio_irq_ctrl #(
    parameter int NUM_PINS   = 24,
    parameter int ID_W       = 5,
    parameter int RES_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_PINS-1:0] INTR,
    input  logic [NUM_PINS-1:0] IRQ_MASK,
    input  logic                CLR_WE,
    input  logic [NUM_PINS-1:0] CLR_DATA,
    output logic [NUM_PINS-1:0] PENDING,
    output logic                IRQ_REQ,
    output logic [ID_W-1:0]     IRQ_ID,
    input  logic                IRQ_ACK,
    output logic [NUM_PINS-1:0] IRQRES
);

    localparam int CNT_W = 4;
    localparam logic [NUM_PINS-1:0] ONE_HOT0 = {{(NUM_PINS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RES
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    res_cnt;
    logic [NUM_PINS-1:0] intr_prev;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] eligible;
    logic [NUM_PINS-1:0] sel_mask;
    logic [NUM_PINS-1:0] ack_clr;
    logic [NUM_PINS-1:0] sw_clr;
    logic [ID_W-1:0]     winner;
    logic                ack_fire;
    logic                frozen_eligible;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rise            = INTR & ~intr_prev;
        eligible        = PENDING & IRQ_MASK;
        sel_mask        = ONE_HOT0 << IRQ_ID;
        ack_fire        = (state == ST_REQ) && IRQ_ACK;
        ack_clr         = ack_fire ? sel_mask : '0;
        sw_clr          = CLR_WE ? CLR_DATA : '0;
        frozen_eligible = |(eligible & sel_mask);
        // Scan downwards so the lowest set index is the last assignment and wins.
        winner = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; it is only seen at a rising edge of CLK.
        if (RST) begin
            state     <= ST_IDLE;
            res_cnt   <= '0;
            intr_prev <= '0;
            PENDING   <= '0;
            IRQ_REQ   <= 1'b0;
            IRQ_ID    <= '0;
            IRQRES    <= '0;
        end else begin
            intr_prev <= INTR;
            // A fresh edge beats a software or ack clear of the same bit.
            PENDING   <= rise | (PENDING & ~sw_clr & ~ack_clr);

            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        IRQ_ID  <= winner;
                        IRQ_REQ <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IRQ_ACK) begin
                        IRQ_REQ <= 1'b0;
                        IRQ_ID  <= '0;
                        IRQRES  <= sel_mask;
                        res_cnt <= CNT_W'(RES_CYCLES - 1);
                        state   <= ST_RES;
                    end else if (!frozen_eligible) begin
                        // Request withdrawn: pin cleared or masked before the CPU answered.
                        IRQ_REQ <= 1'b0;
                        IRQ_ID  <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_RES: begin
                    if (res_cnt == '0) begin
                        IRQRES <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        res_cnt <= res_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: each task drives one scenario and compares outputs
// against hand-computed values one time unit after the rising edge.
module tb_gpio_irq_ctrl;

    localparam int NUM_PINS   = 24;
    localparam int ID_W       = 5;
    localparam int RES_CYCLES = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NUM_PINS-1:0] INTR;
    logic [NUM_PINS-1:0] IRQ_MASK;
    logic                CLR_WE;
    logic [NUM_PINS-1:0] CLR_DATA;
    logic [NUM_PINS-1:0] PENDING;
    logic                IRQ_REQ;
    logic [ID_W-1:0]     IRQ_ID;
    logic                IRQ_ACK;
    logic [NUM_PINS-1:0] IRQRES;

    int vectors     = 0;
    int miscompares = 0;

    gpio_irq_ctrl #(
        .NUM_PINS  (NUM_PINS),
        .ID_W      (ID_W),
        .RES_CYCLES(RES_CYCLES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .INTR    (INTR),
        .IRQ_MASK(IRQ_MASK),
        .CLR_WE  (CLR_WE),
        .CLR_DATA(CLR_DATA),
        .PENDING (PENDING),
        .IRQ_REQ (IRQ_REQ),
        .IRQ_ID  (IRQ_ID),
        .IRQ_ACK (IRQ_ACK),
        .IRQRES  (IRQRES)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge; outputs are then stable and inputs may be changed.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        vectors++; if (PENDING !== 24'h0) begin miscompares++; $display("FAIL reset_pending got %h want %h", PENDING, 24'h0); end
        vectors++; if (IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", IRQ_REQ); end
        vectors++; if (IRQ_ID !== 5'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", IRQ_ID); end
        vectors++; if (IRQRES !== 24'h0) begin miscompares++; $display("FAIL reset_irqres got %h want %h", IRQRES, 24'h0); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_single();
        IRQ_ACK = 1'b1;  // ack while idle must be ignored
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (IRQRES !== 24'h0) begin miscompares++; $display("FAIL idle_ack_irqres got %h want %h", IRQRES, 24'h0); end
        INTR[5] = 1'b1;
        step();
        vectors++; if (PENDING !== 24'h000020) begin miscompares++; $display("FAIL single_pending got %h want %h", PENDING, 24'h000020); end
        vectors++; if (IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL single_req_early got %b want 0", IRQ_REQ); end
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd5) begin miscompares++; $display("FAIL single_req got req=%b id=%0d want req=1 id=5", IRQ_REQ, IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (PENDING !== 24'h0) begin miscompares++; $display("FAIL single_ack_pending got %h want %h", PENDING, 24'h0); end
        vectors++; if (IRQRES !== 24'h000020 || IRQ_REQ !== 1'b0 || IRQ_ID !== 5'd0) begin miscompares++; $display("FAIL single_res1 got res=%h req=%b id=%0d want res=000020 req=0 id=0", IRQRES, IRQ_REQ, IRQ_ID); end
        step();
        vectors++; if (IRQRES !== 24'h000020) begin miscompares++; $display("FAIL single_res2 got %h want %h", IRQRES, 24'h000020); end
        step();
        vectors++; if (IRQRES !== 24'h0) begin miscompares++; $display("FAIL single_res_end got %h want %h", IRQRES, 24'h0); end
        step();
        vectors++; if (IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL single_no_rereq got %b want 0", IRQ_REQ); end
        INTR = '0;
        step();
    endtask

    task automatic test_priority();
        INTR[3]  = 1'b1;
        INTR[17] = 1'b1;
        step();
        vectors++; if (PENDING !== 24'h020008) begin miscompares++; $display("FAIL prio_pending got %h want %h", PENDING, 24'h020008); end
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd3) begin miscompares++; $display("FAIL prio_first got req=%b id=%0d want req=1 id=3", IRQ_REQ, IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (IRQRES !== 24'h000008 || PENDING !== 24'h020000) begin miscompares++; $display("FAIL prio_ack got res=%h pend=%h want res=000008 pend=020000", IRQRES, PENDING); end
        step();
        step();
        vectors++; if (IRQRES !== 24'h0 || IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL prio_res_exit got res=%h req=%b want res=0 req=0", IRQRES, IRQ_REQ); end
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd17) begin miscompares++; $display("FAIL prio_second got req=%b id=%0d want req=1 id=17", IRQ_REQ, IRQ_ID); end
        INTR[1] = 1'b1;
        step();
        vectors++; if (PENDING !== 24'h020002) begin miscompares++; $display("FAIL prio_late_pending got %h want %h", PENDING, 24'h020002); end
        step();
        vectors++; if (IRQ_ID !== 5'd17) begin miscompares++; $display("FAIL prio_no_preempt got id=%0d want 17", IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (IRQRES !== 24'h020000) begin miscompares++; $display("FAIL prio_res17 got %h want %h", IRQRES, 24'h020000); end
        step();
        step();
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd1) begin miscompares++; $display("FAIL prio_third got req=%b id=%0d want req=1 id=1", IRQ_REQ, IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (IRQRES !== 24'h000002) begin miscompares++; $display("FAIL prio_res1 got %h want %h", IRQRES, 24'h000002); end
        step();
        step();
        INTR = '0;
        step();
    endtask

    task automatic test_mask();
        IRQ_MASK[9] = 1'b0;
        INTR[9]     = 1'b1;
        step();
        vectors++; if (PENDING !== 24'h000200) begin miscompares++; $display("FAIL mask_pending got %h want %h", PENDING, 24'h000200); end
        step();
        vectors++; if (IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL mask_blocked got req=%b want 0", IRQ_REQ); end
        IRQ_MASK = '1;
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd9) begin miscompares++; $display("FAIL mask_enable got req=%b id=%0d want req=1 id=9", IRQ_REQ, IRQ_ID); end
        IRQ_MASK[9] = 1'b0;  // masking the frozen pin withdraws the request
        step();
        vectors++; if (IRQ_REQ !== 1'b0 || IRQ_ID !== 5'd0 || IRQRES !== 24'h0) begin miscompares++; $display("FAIL mask_withdraw got req=%b id=%0d res=%h want req=0 id=0 res=0", IRQ_REQ, IRQ_ID, IRQRES); end
        IRQ_MASK = '1;
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd9) begin miscompares++; $display("FAIL mask_rereq got req=%b id=%0d want req=1 id=9", IRQ_REQ, IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        step();
        step();
        INTR = '0;
        step();
    endtask

    task automatic test_withdraw();
        INTR[4] = 1'b1;
        step();
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd4) begin miscompares++; $display("FAIL wd_req got req=%b id=%0d want req=1 id=4", IRQ_REQ, IRQ_ID); end
        CLR_WE   = 1'b1;
        CLR_DATA = 24'h000010;
        step();
        CLR_WE   = 1'b0;
        CLR_DATA = '0;
        vectors++; if (PENDING !== 24'h0) begin miscompares++; $display("FAIL wd_cleared got %h want %h", PENDING, 24'h0); end
        step();
        vectors++; if (IRQ_REQ !== 1'b0 || IRQRES !== 24'h0) begin miscompares++; $display("FAIL wd_dropped got req=%b res=%h want req=0 res=0", IRQ_REQ, IRQRES); end
        step();
        vectors++; if (IRQRES !== 24'h0 || IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL wd_quiet got req=%b res=%h want req=0 res=0", IRQ_REQ, IRQRES); end
        // Re-arm pin 4, then clear it in the same cycle it rises again.
        INTR[4] = 1'b0;
        step();
        INTR[4] = 1'b1;
        step();
        step();
        INTR[4] = 1'b0;
        step();
        INTR[4]  = 1'b1;
        CLR_WE   = 1'b1;
        CLR_DATA = 24'h000010;
        step();
        CLR_WE   = 1'b0;
        CLR_DATA = '0;
        vectors++; if (PENDING !== 24'h000010) begin miscompares++; $display("FAIL wd_set_wins got %h want %h", PENDING, 24'h000010); end
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd4) begin miscompares++; $display("FAIL wd_kept got req=%b id=%0d want req=1 id=4", IRQ_REQ, IRQ_ID); end
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        step();
        step();
        INTR = '0;
        step();
    endtask

    task automatic test_held_level();
        INTR[0] = 1'b1;
        step();
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd0) begin miscompares++; $display("FAIL held_req got req=%b id=%0d want req=1 id=0", IRQ_REQ, IRQ_ID); end
        step();
        step();
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (PENDING !== 24'h0 || IRQRES !== 24'h000001) begin miscompares++; $display("FAIL held_ack got pend=%h res=%h want pend=0 res=000001", PENDING, IRQRES); end
        for (int i = 0; i < 5; i++) step();
        vectors++; if (IRQ_REQ !== 1'b0 || PENDING !== 24'h0) begin miscompares++; $display("FAIL held_no_rereq got req=%b pend=%h want req=0 pend=0", IRQ_REQ, PENDING); end
        INTR = '0;
        step();
    endtask

    task automatic test_reset_mid();
        INTR[2] = 1'b1;
        step();
        step();
        IRQ_ACK = 1'b1;
        step();
        IRQ_ACK = 1'b0;
        vectors++; if (IRQRES !== 24'h000004) begin miscompares++; $display("FAIL rstmid_res got %h want %h", IRQRES, 24'h000004); end
        RST = 1'b1;
        step();
        vectors++; if (IRQRES !== 24'h0 || PENDING !== 24'h0 || IRQ_REQ !== 1'b0) begin miscompares++; $display("FAIL rstmid_abort got res=%h pend=%h req=%b want 0/0/0", IRQRES, PENDING, IRQ_REQ); end
        RST = 1'b0;
        step();
        vectors++; if (PENDING !== 24'h000004) begin miscompares++; $display("FAIL rstmid_edge got %h want %h", PENDING, 24'h000004); end
        step();
        vectors++; if (IRQ_REQ !== 1'b1 || IRQ_ID !== 5'd2) begin miscompares++; $display("FAIL rstmid_req got req=%b id=%0d want req=1 id=2", IRQ_REQ, IRQ_ID); end
    endtask

    initial begin
        RST      = 1'b1;
        INTR     = '0;
        IRQ_MASK = '1;
        CLR_WE   = 1'b0;
        CLR_DATA = '0;
        IRQ_ACK  = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_withdraw();
        test_held_level();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
